data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache_if.sv | 36 +++
 rtl/data_cache.sv | 153 +++++++++++++++
 tb/tb_data_cache.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_if.sv
// Bus bundle for data_cache: pipeline load/store port plus backing-memory port.
// master = pipeline/memory environment, slave = the cache.
interface data_cache_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  // Pipeline side
  logic                  memRead_M;
  logic                  memWrite_M;
  logic [ADDR_WIDTH-1:0] addr_M;
  logic [WIDTH-1:0]      writeData_M;
  logic [WIDTH-1:0]      readData_M;
  logic                  stall_M;

  // Backing-memory side
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  mem_ack;

  modport master (
    output memRead_M, memWrite_M, addr_M, writeData_M,
    input  readData_M, stall_M,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

  modport slave (
    input  memRead_M, memWrite_M, addr_M, writeData_M,
    output readData_M, stall_M,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache
// with hit/miss performance counters.
module data_cache #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SETS       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inv_all,
  data_cache_if.slave bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned IDX   = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_WIDTH - IDX - 2;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_MISS = 2'd1;
  localparam logic [1:0] WR_THRU = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [SETS-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [WIDTH-1:0]      data_q [SETS];
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [31:0]           hit_count_q, hit_count_d;
  logic [31:0]           miss_count_q, miss_count_d;

  logic [IDX-1:0]        req_idx, fill_idx, line_idx;
  logic [TAG_W-1:0]      req_tag, fill_tag, line_tag;
  logic [WIDTH-1:0]      line_data;
  logic                  line_we, tag_we;
  logic                  req_hit;
  logic [WIDTH-1:0]      read_data;
  logic                  stall;

  assign req_idx  = bus.addr_M[IDX+1:2];
  assign req_tag  = bus.addr_M[ADDR_WIDTH-1:IDX+2];
  assign fill_idx = addr_q[IDX+1:2];
  assign fill_tag = addr_q[ADDR_WIDTH-1:IDX+2];

  // A same-cycle invalidate forces the request down the miss path.
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !inv_all;

  // Next-state, line-update and pipeline-output decode.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    line_we      = 1'b0;
    tag_we       = 1'b0;
    line_idx     = req_idx;
    line_tag     = req_tag;
    line_data    = bus.writeData_M;
    read_data    = '0;
    stall        = 1'b0;

    case (state_q)
      IDLE: begin
        if (inv_all) begin
          valid_d = '0;
        end
        if (bus.memWrite_M) begin
          // Store (also covers load+store together): no counter update.
          stall   = 1'b1;
          addr_d  = bus.addr_M;
          wdata_d = bus.writeData_M;
          line_we = req_hit;
          state_d = WR_THRU;
        end else if (bus.memRead_M) begin
          if (req_hit) begin
            read_data = data_q[req_idx];
            if (hit_count_q != '1) begin
              hit_count_d = hit_count_q + 32'd1;
            end
          end else begin
            stall   = 1'b1;
            addr_d  = bus.addr_M;
            state_d = RD_MISS;
            if (miss_count_q != '1) begin
              miss_count_d = miss_count_q + 32'd1;
            end
          end
        end
      end
      RD_MISS: begin
        stall = !bus.mem_ack;
        if (bus.mem_ack) begin
          read_data         = bus.mem_rdata;
          line_we           = 1'b1;
          tag_we            = 1'b1;
          line_idx          = fill_idx;
          line_tag          = fill_tag;
          line_data         = bus.mem_rdata;
          valid_d[fill_idx] = 1'b1;
          state_d           = IDLE;
        end
      end
      WR_THRU: begin
        stall = !bus.mem_ack;
        if (bus.mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, valid bits, captured request and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Line tag/data storage; left unreset since valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!rst && line_we) begin
      data_q[line_idx] <= line_data;
      if (tag_we) begin
        tag_q[line_idx] <= line_tag;
      end
    end
  end

  assign bus.readData_M = read_data;
  assign bus.stall_M    = stall;
  assign bus.mem_req    = (state_q == RD_MISS) || (state_q == WR_THRU);
  assign bus.mem_we     = (state_q == WR_THRU);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign hit_count      = hit_count_q;
  assign miss_count     = miss_count_q;

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: directed scenarios followed by random traffic,
// checked against a set-occupancy model plus an expected-memory image.
module tb_data_cache;
  localparam int unsigned WIDTH      = 32;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned SETS       = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        inv_all;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  data_cache_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  data_cache #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .SETS(SETS)) dut (
    .clk       (clk),
    .rst       (rst),
    .inv_all   (inv_all),
    .bus       (bus),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_write;
    logic [31:0] data;
    int unsigned exp_stall;
  } sb_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mt_t;

  sb_t sb_q[$];
  mt_t mt_q[$];

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: which word each set holds (-1 = empty) and the memory image.
  int          line_word [SETS];
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] bmem [int unsigned];
  int unsigned exp_hits;
  int unsigned exp_misses;

  int unsigned ack_delay;
  bit          resp_en;
  bit          man_ack;
  logic [31:0] man_rdata;

  function automatic logic [31:0] init_val(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] bmem_rd(logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return init_val(a);
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_clear();
    foreach (line_word[i]) line_word[i] = -1;
  endtask

  // Issue one request, push expectations, and wait for stall_M to drop.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input bit inv);
    sb_t e;
    mt_t m;
    int  set;
    bit  hit;
    int  cyc;
    set = int'((a >> 2) % SETS);
    if (inv) model_clear();
    hit = (line_word[set] == int'(a >> 2));
    @(posedge clk); #1;
    if (wr) begin
      e.is_write  = 1'b1;
      e.data      = '0;
      e.exp_stall = ack_delay + 1;
      m.we = 1'b1; m.addr = a; m.wdata = wd;
      mt_q.push_back(m);
      ref_mem[a] = wd;
    end else begin
      e.is_write  = 1'b0;
      e.data      = ref_rd(a);
      e.exp_stall = hit ? 0 : ack_delay + 1;
      if (hit) begin
        exp_hits++;
      end else begin
        exp_misses++;
        line_word[set] = int'(a >> 2);
        m.we = 1'b0; m.addr = a; m.wdata = '0;
        mt_q.push_back(m);
      end
    end
    sb_q.push_back(e);
    bus.memRead_M   = rd;
    bus.memWrite_M  = wr;
    bus.addr_M      = a;
    bus.writeData_M = wd;
    inv_all         = inv;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!bus.stall_M) break;
      cyc++;
      if (cyc > 40) begin
        checks++;
        errors++;
        $display("FAIL req_timeout: stall_M=%0b after %0d cycles, expected 0", bus.stall_M, cyc);
        break;
      end
      @(posedge clk); #1 inv_all = 1'b0;
    end
  endtask

  // One idle cycle, then compare counters and quiescent outputs.
  task automatic check_idle(string tag);
    @(posedge clk); #1;
    bus.memRead_M  = 1'b0;
    bus.memWrite_M = 1'b0;
    inv_all        = 1'b0;
    @(negedge clk);
    check({tag, "_hit_count"}, hit_count, exp_hits);
    check({tag, "_miss_count"}, miss_count, exp_misses);
    check({tag, "_idle_rdata"}, bus.readData_M, 32'h0);
    check({tag, "_idle_stall"}, {31'h0, bus.stall_M}, 32'h0);
    check({tag, "_idle_mem_req"}, {31'h0, bus.mem_req}, 32'h0);
  endtask

  task automatic model_reset();
    model_clear();
    exp_hits   = 0;
    exp_misses = 0;
    sb_q.delete();
    mt_q.delete();
  endtask

  // Monitor: on each request completion, pop the scoreboard and compare.
  initial begin : monitor
    int  stall_cyc;
    sb_t e;
    stall_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cyc = 0;
      end else if (bus.memRead_M || bus.memWrite_M) begin
        if (bus.stall_M) begin
          stall_cyc++;
        end else begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: completion seen with no expected entry at %0t", $time);
          end else begin
            e = sb_q.pop_front();
            if (!e.is_write) check("read_data", bus.readData_M, e.data);
            check("stall_cycles", stall_cyc, e.exp_stall);
          end
          stall_cyc = 0;
        end
      end
    end
  end

  // Backing-memory responder: acks ack_delay cycles after mem_req rises.
  initial begin : responder
    bit  active;
    int  cnt;
    int  dly;
    mt_t m;
    active = 1'b0;
    cnt    = 0;
    dly    = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      if (!resp_en) begin
        active      = 1'b0;
        bus.mem_ack = man_ack;
        if (man_ack) bus.mem_rdata = man_rdata;
      end else begin
        if (active && !bus.mem_req) active = 1'b0;
        if (!active && bus.mem_req) begin
          active = 1'b1;
          cnt    = 0;
          dly    = int'(ack_delay);
          if (mt_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected: mem_req=1 addr 0x%08h, expected no request",
                     bus.mem_addr);
            m.we = bus.mem_we; m.addr = bus.mem_addr; m.wdata = bus.mem_wdata;
          end else begin
            m = mt_q.pop_front();
          end
        end
        if (active) begin
          check("mem_we", {31'h0, bus.mem_we}, {31'h0, m.we});
          check("mem_addr", bus.mem_addr, m.addr);
          if (m.we) check("mem_wdata", bus.mem_wdata, m.wdata);
          if (cnt == dly) begin
            bus.mem_ack = 1'b1;
            if (m.we) bmem[m.addr] = m.wdata;
            else      bus.mem_rdata = bmem_rd(m.addr);
            active = 1'b0;
          end else begin
            cnt++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          op;
    logic [31:0] a;
    logic [31:0] wd;
    rst             = 1'b1;
    inv_all         = 1'b0;
    bus.memRead_M   = 1'b0;
    bus.memWrite_M  = 1'b0;
    bus.addr_M      = '0;
    bus.writeData_M = '0;
    resp_en         = 1'b1;
    man_ack         = 1'b0;
    man_rdata       = '0;
    ack_delay       = 2;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_hit_count", hit_count, 32'h0);
    check("reset_miss_count", miss_count, 32'h0);
    check("reset_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("reset_mem_we", {31'h0, bus.mem_we}, 32'h0);

    // Cold miss with a 2-cycle ack: 3 stalled cycles, data on ack cycle.
    ref_mem[32'h40] = 32'hDEADBEEF;
    bmem[32'h40]    = 32'hDEADBEEF;
    ack_delay = 2;
    do_req(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    check_idle("cold_miss");
    // Repeat read hits with zero stall.
    do_req(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    check_idle("rehit");
    // Write-through hit, then read back updated data.
    do_req(1'b0, 1'b1, 32'h40, 32'h12345678, 1'b0);
    do_req(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    check_idle("write_hit");
    // Conflict on same index: 0x80 evicts 0x40, which then misses again.
    ack_delay = 1;
    do_req(1'b1, 1'b0, 32'h80, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    check_idle("conflict");

    // Reset in the middle of a miss, then a stray ack while idle.
    resp_en = 1'b0;
    @(posedge clk); #1;
    bus.memRead_M  = 1'b1;
    bus.memWrite_M = 1'b0;
    bus.addr_M     = 32'h80;
    @(posedge clk); #1;
    @(negedge clk);
    check("midmiss_mem_req", {31'h0, bus.mem_req}, 32'h1);
    @(posedge clk); #1;
    rst           = 1'b1;
    bus.memRead_M = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("after_rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    man_ack   = 1'b1;
    man_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    man_ack = 1'b0;
    check_idle("stray_ack");
    resp_en = 1'b1;
    do_req(1'b1, 1'b0, 32'h80, 32'h0, 1'b0);
    check_idle("post_rst_miss");

    // Invalidate-all on its own, then with a same-cycle request.
    do_req(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    @(posedge clk); #1;
    bus.memRead_M = 1'b0;
    inv_all       = 1'b1;
    model_clear();
    @(posedge clk); #1 inv_all = 1'b0;
    do_req(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
    check_idle("inv_all");

    // Random traffic over a small footprint so hits and conflicts are frequent.
    for (int n = 0; n < 300; n++) begin
      op        = int'($urandom_range(0, 9));
      a         = $urandom_range(0, 63) << 2;
      wd        = $urandom;
      ack_delay = $urandom_range(0, 3);
      if (op <= 5)      do_req(1'b1, 1'b0, a, wd, 1'b0);
      else if (op <= 7) do_req(1'b0, 1'b1, a, wd, 1'b0);
      else if (op == 8) do_req(1'b1, 1'b1, a, wd, 1'b0);
      else              do_req(1'b1, 1'b0, a, wd, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        bus.memRead_M  = 1'b0;
        bus.memWrite_M = 1'b0;
        inv_all        = 1'b0;
      end
    end
    check_idle("random");
    check("sb_drained", sb_q.size(), 32'h0);
    check("mem_drained", mt_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
